gmii_to_wide_pkt: RTL and testbench

- Packs a byte-wide GMII receive stream into BYTES-wide packet beats with SOP/EOP/valid-byte tags, on a single clock.
- Parametrised successor of the fixed 16-byte, dual-clock accumulator. It adds configurable width, runt/oversize/error filtering, store-and-forward commit/rollback, ready/valid output and per-cause drop counters.
- Sits between the MAC receive path and the packet parser. Any clock crossing is handled downstream.

---
 rtl/gmii_to_wide_pkt.sv | 196 +++++++++++++++++++
 tb/tb_gmii_to_wide_pkt.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_to_wide_pkt.sv
// gmii_to_wide_pkt: packs a GMII receive byte stream into BYTES-wide packet beats with
// runt/error/oversize filtering, store-and-forward commit/rollback and per-cause drop counters.
// Ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   gmii_data            receive byte
//   gmii_data_valid      byte valid; a frame is a contiguous run of high cycles
//   gmii_er              receive error; any assertion within a frame marks it bad
//   out_data             beat data, first byte at MSBs, invalid bytes zero
//   out_sop / out_eop    first / last beat of a packet
//   out_vbytes           valid bytes minus 1 on the last beat, all-ones otherwise
//   out_len              frame length in bytes, meaningful while out_sop=1
//   out_valid/out_ready  beat handshake
//   cnt_pkt              packets committed
//   cnt_drop_runt        frames dropped as shorter than MIN_LEN
//   cnt_drop_err         frames dropped for gmii_er
//   cnt_drop_ovf         frames dropped as longer than MAX_LEN or for lack of buffer space
module gmii_to_wide_pkt #(
    parameter int BYTES     = 16,
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 2048,
    parameter int DEPTH     = 512,
    parameter int LEN_DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               gmii_data,
    input  logic                     gmii_data_valid,
    input  logic                     gmii_er,
    output logic [8*BYTES-1:0]       out_data,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [$clog2(BYTES)-1:0] out_vbytes,
    output logic [15:0]              out_len,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              cnt_pkt,
    output logic [31:0]              cnt_drop_runt,
    output logic [31:0]              cnt_drop_err,
    output logic [31:0]              cnt_drop_ovf
);
    localparam int VW   = $clog2(BYTES);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = $clog2(LEN_DEPTH);
    localparam int MAXB = (MAX_LEN + BYTES - 1) / BYTES;
    localparam int W    = 8 * BYTES;

    typedef enum logic [1:0] {SYNC, IDLE, RECV, DROP} state_t;

    state_t       state;
    logic [W-1:0] mem [DEPTH];
    logic [15:0]  dq_len [LEN_DEPTH];
    logic [15:0]  dq_beats [LEN_DEPTH];
    logic [AW:0]  wr_ptr, cm_ptr, rd_ptr;
    logic [LW:0]  dq_wp, dq_rp;
    logic [W-1:0] acc;
    logic [15:0]  len;
    logic         err;
    logic         act;
    logic [15:0]  rbeats;

    logic [W-1:0] acc_sh, pad, wdata;
    logic [VW:0]  gap;
    logic [15:0]  len_inc, beats, cur_beats, cur_len;
    logic [AW:0]  wr_end, used;
    logic         eof, commit, we, space_ok, dq_ne, ld, last;

    always_comb begin
        // bytes shift in at the LSB end; the oldest byte of a beat ends up at the MSBs
        acc_sh    = {acc[W-9:0], gmii_data};
        len_inc   = len + 16'd1;
        // a trailing partial beat holds its k bytes in the low end; shift them up to the MSBs,
        // which also discards stale bytes of the previous beat and zero-fills the tail
        gap       = (VW+1)'(BYTES) - {1'b0, len[VW-1:0]};
        pad       = acc << {gap, 3'b000};
        beats     = (len >> VW) + 16'(len[VW-1:0] != '0);
        eof       = state == RECV && !gmii_data_valid;
        commit    = eof && !err && len >= 16'(MIN_LEN);
        wr_end    = wr_ptr + (AW+1)'(len[VW-1:0] != '0);
        used      = cm_ptr - rd_ptr;
        space_ok  = used <= (AW+1)'(DEPTH - MAXB) && (dq_wp - dq_rp) != (LW+1)'(LEN_DEPTH);
        we        = state == RECV && (gmii_data_valid ? (len != 16'(MAX_LEN) && len_inc[VW-1:0] == '0)
                                                      : len[VW-1:0] != '0);
        wdata     = gmii_data_valid ? acc_sh : pad;
        dq_ne     = dq_wp != dq_rp;
        ld        = (!out_valid || out_ready) && (act || dq_ne);
        cur_beats = act ? rbeats : dq_beats[dq_rp[LW-1:0]];
        // out_len keeps the current packet's length for the rest of the packet
        cur_len   = act ? out_len : dq_len[dq_rp[LW-1:0]];
        last      = cur_beats == 16'd1;
    end

    // Beat buffer and descriptor queue storage (no reset so they map onto RAM)
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_ptr[AW-1:0]] <= wdata;
        if (commit) begin
            dq_len[dq_wp[LW-1:0]]   <= len;
            dq_beats[dq_wp[LW-1:0]] <= beats;
        end
    end

    // Receiver: frame accumulation, end-of-frame decision and drop accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SYNC;
            wr_ptr        <= '0;
            cm_ptr        <= '0;
            dq_wp         <= '0;
            acc           <= '0;
            len           <= '0;
            err           <= 1'b0;
            cnt_pkt       <= '0;
            cnt_drop_runt <= '0;
            cnt_drop_err  <= '0;
            cnt_drop_ovf  <= '0;
        end else begin
            case (state)
                SYNC: if (!gmii_data_valid) state <= IDLE;
                IDLE: if (gmii_data_valid) begin
                    if (space_ok) begin
                        state <= RECV;
                        acc   <= acc_sh;
                        len   <= 16'd1;
                        err   <= gmii_er;
                    end else begin
                        state        <= DROP;
                        cnt_drop_ovf <= cnt_drop_ovf + 32'd1;
                    end
                end
                RECV: if (gmii_data_valid) begin
                    if (len == 16'(MAX_LEN)) begin
                        state        <= DROP;
                        wr_ptr       <= cm_ptr;
                        cnt_drop_ovf <= cnt_drop_ovf + 32'd1;
                    end else begin
                        acc <= acc_sh;
                        len <= len_inc;
                        err <= err | gmii_er;
                        if (len_inc[VW-1:0] == '0)
                            wr_ptr <= wr_ptr + (AW+1)'(1);
                    end
                end else begin
                    state <= IDLE;
                    if (err) begin
                        wr_ptr       <= cm_ptr;
                        cnt_drop_err <= cnt_drop_err + 32'd1;
                    end else if (!commit) begin
                        wr_ptr        <= cm_ptr;
                        cnt_drop_runt <= cnt_drop_runt + 32'd1;
                    end else begin
                        wr_ptr  <= wr_end;
                        cm_ptr  <= wr_end;
                        dq_wp   <= dq_wp + (LW+1)'(1);
                        cnt_pkt <= cnt_pkt + 32'd1;
                    end
                end
                DROP: begin
                    wr_ptr <= cm_ptr;
                    if (!gmii_data_valid) state <= IDLE;
                end
                default: state <= SYNC;
            endcase
        end
    end

    // Output: registered beat stage; the next beat is fetched whenever the stage is empty or
    // being accepted, so consecutive packets stream without a gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_vbytes <= '0;
            out_len    <= '0;
            rd_ptr     <= '0;
            dq_rp      <= '0;
            act        <= 1'b0;
            rbeats     <= '0;
        end else if (ld) begin
            out_valid  <= 1'b1;
            out_data   <= mem[rd_ptr[AW-1:0]];
            out_sop    <= !act;
            out_eop    <= last;
            out_len    <= cur_len;
            out_vbytes <= last ? VW'(cur_len - 16'd1) : '1;
            rbeats     <= cur_beats - 16'd1;
            act        <= !last;
            rd_ptr     <= rd_ptr + (AW+1)'(1);
            if (!act)
                dq_rp <= dq_rp + (LW+1)'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gmii_to_wide_pkt.sv
// tb_gmii_to_wide_pkt: randomized self-checking bench for gmii_to_wide_pkt against a
// queue-based packet model (expected bytes per committed frame, per-cause drop counts).
module tb_gmii_to_wide_pkt;
    localparam int BYTES     = 16;
    localparam int MIN_LEN   = 64;
    localparam int MAX_LEN   = 2048;
    localparam int DEPTH     = 512;
    localparam int LEN_DEPTH = 64;
    localparam int MAXB      = (MAX_LEN + BYTES - 1) / BYTES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   gmii_data = '0;
    logic         gmii_data_valid = 1'b0;
    logic         gmii_er = 1'b0;
    logic [127:0] out_data;
    logic         out_sop, out_eop, out_valid;
    logic [3:0]   out_vbytes;
    logic [15:0]  out_len;
    logic         out_ready = 1'b0;
    logic [31:0]  cnt_pkt, cnt_drop_runt, cnt_drop_err, cnt_drop_ovf;

    gmii_to_wide_pkt #(
        .BYTES(BYTES), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .DEPTH(DEPTH), .LEN_DEPTH(LEN_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .gmii_data(gmii_data), .gmii_data_valid(gmii_data_valid),
        .gmii_er(gmii_er), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_vbytes(out_vbytes), .out_len(out_len), .out_valid(out_valid), .out_ready(out_ready),
        .cnt_pkt(cnt_pkt), .cnt_drop_runt(cnt_drop_runt), .cnt_drop_err(cnt_drop_err),
        .cnt_drop_ovf(cnt_drop_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    byte unsigned exp_bytes[$];
    int exp_lens[$];
    int bi = 0;
    int m_pkt = 0, m_runt = 0, m_err = 0, m_ovf = 0;
    int committed_beats = 0, xfer_beats = 0;
    int ready_mode = 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // out_ready: 0 = stalled, 1 = always ready, 2 = random
    always @(posedge clk) begin
        #1;
        out_ready = (ready_mode == 2) ? 1'($urandom) : (ready_mode == 1);
    end

    // Compare process: every valid beat must equal the head beat of the model
    always @(negedge clk) begin : mon
        int n;
        bit lst;
        logic [127:0] ed;
        if (!rst_n) begin
            check("reset_valid", 128'(out_valid), 128'd0);
        end else if (out_valid) begin
            if (exp_lens.size() == 0) begin
                check("unexpected_beat", 128'(out_valid), 128'd0);
            end else begin
                n = exp_lens[0];
                ed = '0;
                for (int j = 0; j < BYTES; j++)
                    if (bi * BYTES + j < n) ed[127 - 8*j -: 8] = exp_bytes[bi * BYTES + j];
                lst = (bi + 1) * BYTES >= n;
                check("beat_data", out_data, ed);
                check("beat_flags", {out_sop, out_eop, out_vbytes},
                      {bi == 0, lst, lst ? 4'(n - bi * BYTES - 1) : 4'hf});
                if (bi == 0) check("beat_len", 128'(out_len), 128'(n));
                if (out_ready) begin
                    xfer_beats++;
                    if (lst) begin
                        repeat (n) void'(exp_bytes.pop_front());
                        void'(exp_lens.pop_front());
                        bi = 0;
                    end else begin
                        bi++;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Drive one frame (followed by one idle cycle) and update the model from the frame rules
    task automatic send_frame(input int n, input int er_at, input bit seq);
        byte unsigned fb[$];
        byte unsigned b;
        bit ok;
        ok = (committed_beats - xfer_beats) <= DEPTH - MAXB && exp_lens.size() < LEN_DEPTH;
        for (int i = 0; i < n; i++) begin
            b = seq ? 8'(i) : 8'($urandom);
            fb.push_back(b);
            @(posedge clk); #1;
            gmii_data_valid = 1'b1;
            gmii_data = b;
            gmii_er = (i == er_at);
        end
        @(posedge clk); #1;
        gmii_data_valid = 1'b0;
        gmii_er = 1'b0;
        gmii_data = '0;
        if (!ok || n > MAX_LEN) m_ovf++;
        else if (er_at >= 0 && er_at < n) m_err++;
        else if (n < MIN_LEN) m_runt++;
        else begin
            m_pkt++;
            committed_beats += (n + BYTES - 1) / BYTES;
            exp_lens.push_back(n);
            foreach (fb[i]) exp_bytes.push_back(fb[i]);
        end
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while ((exp_lens.size() != 0 || out_valid) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 128'(k < limit), 128'd1);
        idle(2);
    endtask

    task automatic cmp_counters(input string tag);
        check({tag, "_cnt_pkt"}, 128'(cnt_pkt), 128'(m_pkt));
        check({tag, "_cnt_runt"}, 128'(cnt_drop_runt), 128'(m_runt));
        check({tag, "_cnt_err"}, 128'(cnt_drop_err), 128'(m_err));
        check({tag, "_cnt_ovf"}, 128'(cnt_drop_ovf), 128'(m_ovf));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k, nb;
        bit inpkt, done;
        logic [3:0] vb;
        ready_mode = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {out_valid, out_sop, out_eop, out_vbytes, out_len, out_data}, 128'd0);
        check("reset_counters", {cnt_pkt, cnt_drop_runt, cnt_drop_err, cnt_drop_ovf}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);

        // 100-byte counting frame: 7 beats
        send_frame(100, -1, 1);
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("out_valid_latency", 128'(k <= 3), 128'd1);
        check("t1_beat0_data", out_data, 128'h000102030405060708090a0b0c0d0e0f);
        check("t1_beat0_sop_len", {out_sop, out_len}, {1'b1, 16'd100});
        k = 0;
        while (!(out_valid && out_eop) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t1_last_data", out_data, {32'h60616263, 96'h0});
        check("t1_last_vbytes", 128'(out_vbytes), 128'd3);
        drain(100);
        check("t1_cnt_pkt", 128'(cnt_pkt), 128'd1);

        // runt, error, oversize, then a good frame
        send_frame(40, -1, 1);
        send_frame(64, 10, 1);
        send_frame(2049, -1, 1);
        idle(4);
        check("t2_drop_counts", {cnt_pkt, cnt_drop_runt, cnt_drop_err, cnt_drop_ovf},
              {32'd1, 32'd1, 32'd1, 32'd1});
        send_frame(64, -1, 0);
        drain(100);
        check("t2_cnt_pkt", 128'(cnt_pkt), 128'd2);

        // stalled output, back-to-back 1518-byte frames until the buffer runs out of room
        ready_mode = 0;
        idle(2);
        for (int f = 0; f < 8; f++) send_frame(1518, -1, 0);
        idle(4);
        check("t3_cnt_pkt", 128'(cnt_pkt), 128'd7);
        check("t3_cnt_ovf", 128'(cnt_drop_ovf), 128'd4);
        ready_mode = 1;
        drain(2000);
        cmp_counters("t3");

        // random out_ready on a 64-byte frame
        ready_mode = 2;
        send_frame(64, -1, 0);
        drain(500);
        check("t4_cnt_pkt", 128'(cnt_pkt), 128'd8);

        // exactly MIN_LEN and MAX_LEN
        ready_mode = 1;
        send_frame(MIN_LEN, -1, 1);
        send_frame(MAX_LEN, -1, 1);
        k = 0; nb = 0; inpkt = 0; done = 0; vb = '0;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
            if (out_valid && out_ready) begin
                if (out_sop && out_len == 16'd2048) inpkt = 1;
                if (inpkt) begin
                    nb++;
                    if (out_eop) begin
                        done = 1;
                        vb = out_vbytes;
                    end
                end
            end
        end
        check("t6_max_beats", 128'(nb), 128'd128);
        check("t6_max_vbytes", 128'(vb), 128'd15);
        drain(500);
        check("t6_cnt_pkt", 128'(cnt_pkt), 128'd10);

        // randomized frames with random out_ready
        ready_mode = 2;
        for (int f = 0; f < 30; f++) begin
            int r, n, e;
            r = $urandom_range(0, 9);
            n = (r == 0) ? int'($urandom_range(2049, 2060)) :
                (r == 1) ? int'($urandom_range(1, 63)) : int'($urandom_range(64, 300));
            e = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            send_frame(n, e, 0);
            idle($urandom_range(0, 3));
        end
        drain(20000);
        cmp_counters("rand");

        // reset with a packet held at the output and a frame in progress
        ready_mode = 0;
        send_frame(100, -1, 0);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            gmii_data_valid = 1'b1;
            gmii_data = 8'($urandom);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_bytes.delete();
        exp_lens.delete();
        bi = 0;
        m_pkt = 0; m_runt = 0; m_err = 0; m_ovf = 0;
        committed_beats = 0; xfer_beats = 0;
        @(negedge clk);
        check("rst_outputs", {out_valid, out_sop, out_eop, out_vbytes, out_len, out_data}, 128'd0);
        check("rst_counters", {cnt_pkt, cnt_drop_runt, cnt_drop_err, cnt_drop_ovf}, 128'd0);
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            gmii_data = 8'($urandom);
        end
        @(posedge clk); #1;
        gmii_data_valid = 1'b0;
        ready_mode = 1;
        idle(5);
        @(negedge clk);
        check("rst_tail_ignored", {out_valid, cnt_pkt, cnt_drop_runt, cnt_drop_err, cnt_drop_ovf}, 128'd0);
        send_frame(80, -1, 1);
        drain(200);
        check("rst_next_frame_pkt", 128'(cnt_pkt), 128'd1);
        cmp_counters("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
